flp_rx: RTL and testbench
=========================

Name: flp_rx

Overview:
- Receive-side Fast Link Pulse decoder for the 10BASE-T autonegotiation path. It is the counterpart of the FLP burst transmitter.
- Samples the line-receiver pulse output and recovers clock and data pulses from their timing. Extracts the 16-bit link code word, bit 0 first.
- Flags a completed word, malformed bursts and isolated normal link pulses (NLP) to the autonegotiation control logic.
- Runs at the 20 MHz system clock. All timing parameters are in clk cycles.

Parameters:
- DATA_MIN, 1000: earliest cycle after a clock pulse at which a data pulse is accepted.
- DATA_MAX, 1500: latest cycle after a clock pulse at which a data pulse is accepted. Also the bit commit point.
- CLK_MIN, 2200: earliest cycle after a clock pulse at which the next clock pulse is accepted.
- CLK_MAX, 2800: latest cycle for the next clock pulse. The cycle after it is the timeout.
- IDLE_GAP, 20000: number of quiet cycles (no edges) required before a new burst is armed.
- CNT_W, 16: width of the interval counter. Must hold IDLE_GAP.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- Rx, input, 1: raw link-pulse input. Asynchronous to clk; pulses are 3-10 cycles wide.
- flp_data, output, 16: last successfully received code word. Holds until the next valid word.
- go, output, 1: one-cycle strobe. flp_data has been updated this cycle.
- flp_err, output, 1: one-cycle strobe. Burst aborted (timing violation).
- nlp, output, 1: one-cycle strobe. Isolated single pulse detected.

Behaviour:
- Reset (async, rst_n=0):
  - flp_data=0; go=0; flp_err=0; nlp=0.
  - Synchronizer flops=0, counter=0, bit index=0, shift register=0, state=IDLE.
  - Reset mid-burst discards the partial word. No strobe is issued.
- Input conditioning:
  - Two-flop synchronizer, then rising-edge detect. This gives `edge`, a 1-cycle event.
  - The edge is 3 cycles after the Rx rise.
  - Pulse width is not checked. Only rising edges matter.
- Counter `cnt`:
  - Cleared to 0 on the cycle after any edge accepted as a clock pulse. Otherwise it increments and saturates at all-ones.
  - Window comparisons use the cnt value in the edge cycle. All window bounds are inclusive.
- States:
  - IDLE:
    - cnt counts quiet cycles and is reset to 0 by every edge.
    - When cnt reaches IDLE_GAP, go to ARMED.
  - ARMED:
    - The first edge is clock pulse 0. Go to DATA with index=0, data_seen=0, cnt cleared.
  - DATA (cnt in 0..DATA_MAX):
    - Edge with cnt < DATA_MIN: flp_err=1 next cycle, go to IDLE.
    - Edge with DATA_MIN <= cnt <= DATA_MAX and data_seen=0: set data_seen=1.
    - Second edge in the window: flp_err=1, go to IDLE.
    - At cnt == DATA_MAX: commit shift[index] = data_seen (an edge in that same cycle counts as 1). Clear data_seen, increment index, go to CLOCK.
  - CLOCK (cnt in DATA_MAX+1..CLK_MAX):
    - Edge with cnt < CLK_MIN: flp_err=1, go to IDLE.
    - Edge with CLK_MIN <= cnt <= CLK_MAX and index < 16: accept as a clock pulse. Clear cnt, go to DATA.
    - Edge in the window with index == 16: the extra pulse is ignored. Go to IDLE; that edge restarts the quiet count. The word is still delivered as below.
    - At cnt == CLK_MAX with no edge, one of three outcomes:
      - index == 16: flp_data = shift, go=1 next cycle, go to IDLE.
      - index == 1 and no data pulse was seen: nlp=1 next cycle, go to IDLE.
      - Otherwise: flp_err=1, go to IDLE.
    - The word from an extra-pulse exit at index 16 is delivered the same way: flp_data = shift and go=1 in the cycle after the exit.
- Strobes:
  - go, flp_err and nlp are mutually exclusive and last exactly one cycle.
  - flp_data changes only in the cycle go is asserted.
- Latency: go rises one cycle after cnt == CLK_MAX following the 16th clock pulse.
- Edges arriving in IDLE are never decoded. Bursts without the preceding IDLE_GAP quiet time are ignored.
- Bit order: bit n belongs to the nth clock pulse, bit 0 first. A clock pulse followed by a data pulse means 1; a clock pulse alone means 0.

Test Plan:
- Transmitter-style burst, flp_data=16'hA5C3: clock pulses every 2488 cycles, data pulses 1244 cycles after each clock pulse, preceded by 25000 quiet cycles -> one go pulse; flp_data=16'hA5C3; no flp_err/nlp.
- Burst of 16'h0000, then 16'hFFFF, each after an IDLE_GAP -> go twice; flp_data=0000 then FFFF.
- Single pulse after quiet, then silence -> nlp=1 exactly once, about 2801 cycles after the edge; flp_data unchanged.
- Valid burst with the data pulse of bit 5 moved to 1800 cycles after its clock pulse -> flp_err=1; no go; flp_data holds its previous value.
- Edges at exactly cnt=DATA_MIN, DATA_MAX, CLK_MIN and CLK_MAX -> all accepted. cnt=DATA_MIN-1 -> flp_err.
- rst_n pulsed low at bit 8 of a burst, then a complete burst after an IDLE_GAP -> no strobe at reset; outputs 0 during reset; second burst produces go with the correct word.

Source files
------------

// File: rtl/flp_rx.sv
// Fast Link Pulse receiver: recovers clock/data pulses from their timing and
// assembles the 16-bit link code word (bit 0 first), flagging complete words,
// aborted bursts and isolated normal link pulses.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | counting quiet cycles since the last edge; edges are ignored
// S_ARMED | quiet gap satisfied; next edge is clock pulse 0
// S_DATA  | after a clock pulse, waiting for an optional data pulse
// S_CLOCK | bit committed, waiting for the next clock pulse or timeout
module flp_rx #(
  parameter int unsigned DATA_MIN = 1000,
  parameter int unsigned DATA_MAX = 1500,
  parameter int unsigned CLK_MIN  = 2200,
  parameter int unsigned CLK_MAX  = 2800,
  parameter int unsigned IDLE_GAP = 20000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Rx,
  output logic [15:0] flp_data,
  output logic        go,
  output logic        flp_err,
  output logic        nlp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DATA,
    S_CLOCK
  } state_t;

  localparam logic [CNT_W-1:0] DATA_MIN_C = CNT_W'(DATA_MIN);
  localparam logic [CNT_W-1:0] DATA_MAX_C = CNT_W'(DATA_MAX);
  localparam logic [CNT_W-1:0] CLK_MIN_C  = CNT_W'(CLK_MIN);
  localparam logic [CNT_W-1:0] CLK_MAX_C  = CNT_W'(CLK_MAX);
  localparam logic [CNT_W-1:0] IDLE_GAP_C = CNT_W'(IDLE_GAP);
  localparam logic [4:0]       BITS_C     = 5'd16;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_edge;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic [4:0]       idx;
  logic [4:0]       idx_nxt;
  logic             data_seen;
  logic             data_seen_nxt;
  logic [15:0]      shift;
  logic [15:0]      shift_nxt;
  logic             go_nxt;
  logic             err_nxt;
  logic             nlp_nxt;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= Rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_edge = rx_sync & ~rx_prev;

  // Interval counter: cleared on request, otherwise counts up and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // FSM and word-assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      data_seen <= 1'b0;
      shift     <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      data_seen <= data_seen_nxt;
      shift     <= shift_nxt;
    end
  end

  // Next-state decode. Every exit to IDLE clears cnt so the quiet count
  // starts fresh; an edge in DATA/CLOCK takes priority over the window-end
  // action of the same cycle.
  always_comb begin
    state_nxt     = state;
    cnt_clr       = 1'b0;
    idx_nxt       = idx;
    data_seen_nxt = data_seen;
    shift_nxt     = shift;
    go_nxt        = 1'b0;
    err_nxt       = 1'b0;
    nlp_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_edge) begin
          cnt_clr = 1'b1;
        end else if (cnt >= IDLE_GAP_C) begin
          state_nxt = S_ARMED;
        end
      end

      S_ARMED: begin
        if (rx_edge) begin
          state_nxt     = S_DATA;
          cnt_clr       = 1'b1;
          idx_nxt       = '0;
          data_seen_nxt = 1'b0;
          shift_nxt     = '0;
        end
      end

      S_DATA: begin
        if (rx_edge && ((cnt < DATA_MIN_C) || data_seen)) begin
          // Early pulse or a second pulse inside the data window.
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
          cnt_clr   = 1'b1;
        end else if (cnt >= DATA_MAX_C) begin
          shift_nxt[idx[3:0]] = data_seen | rx_edge;
          data_seen_nxt       = 1'b0;
          idx_nxt             = idx + 5'd1;
          state_nxt           = S_CLOCK;
        end else if (rx_edge) begin
          data_seen_nxt = 1'b1;
        end
      end

      S_CLOCK: begin
        if (rx_edge) begin
          cnt_clr = 1'b1;
          if (cnt < CLK_MIN_C) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (idx == BITS_C) begin
            // Trailing clock pulse after a full word: deliver and drop it.
            go_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
          end
        end else if (cnt >= CLK_MAX_C) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
          if (idx == BITS_C) begin
            go_nxt = 1'b1;
          end else if ((idx == 5'd1) && !shift[0]) begin
            nlp_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Registered strobes; the delivered word only changes alongside go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flp_data <= '0;
      go       <= 1'b0;
      flp_err  <= 1'b0;
      nlp      <= 1'b0;
    end else begin
      go      <= go_nxt;
      flp_err <= err_nxt;
      nlp     <= nlp_nxt;
      if (go_nxt) begin
        flp_data <= shift;
      end
    end
  end

endmodule

// File: tb/tb_flp_rx.sv
// Self-checking bench for flp_rx. The decoder timing is scaled down by ten
// so every burst fits in a short run; stimulus offsets scale with it.
module tb_flp_rx;

  localparam int DATA_MIN = 100;
  localparam int DATA_MAX = 150;
  localparam int CLK_MIN  = 220;
  localparam int CLK_MAX  = 280;
  localparam int IDLE_GAP = 2000;

  localparam int PW       = 5;              // Rx pulse width
  localparam int T_CLK    = 249;            // clock pulse spacing
  localparam int T_DAT    = 125;            // data pulse offset after clock
  localparam int QUIET    = 2500;           // quiet time before a burst
  localparam int LAT_TO   = CLK_MAX + 4;    // Rx rise of last clock -> timeout strobe
  localparam int LAT_EDGE = 3;              // Rx rise -> strobe caused by that edge

  localparam logic [2:0] K_GO  = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_NLP = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Rx = 1'b0;
  logic [15:0] flp_data;
  logic        go;
  logic        flp_err;
  logic        nlp;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [15:0] prev_data = '0;
  logic [15:0] last_word = '0;
  ev_t         mon_ev;

  int          sp[16];
  int          doff[16];
  int          clk_rise[17];
  int          dat_rise[16];

  flp_rx #(
    .DATA_MIN(DATA_MIN),
    .DATA_MAX(DATA_MAX),
    .CLK_MIN (CLK_MIN),
    .CLK_MAX (CLK_MAX),
    .IDLE_GAP(IDLE_GAP),
    .CNT_W   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Rx      (Rx),
    .flp_data(flp_data),
    .go      (go),
    .flp_err (flp_err),
    .nlp     (nlp)
  );

  always #25 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every strobe, plus any change of flp_data that is not paired with go.
  always @(negedge clk) begin
    if (rst_n && (({go, flp_err, nlp} != 3'b000) || ((flp_data !== prev_data) && !go))) begin
      mon_ev.kind = {go, flp_err, nlp};
      mon_ev.data = flp_data;
      mon_ev.cyc  = cyc;
      obs_q.push_back(mon_ev);
    end
    prev_data = flp_data;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 16; i++) begin
      sp[i]   = T_CLK;
      doff[i] = T_DAT;
    end
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [15:0] data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Drives nbits clock pulses (with data pulses for 1 bits), an optional
  // trailing clock pulse, then tail idle cycles. Called on a negedge.
  task automatic send_burst(input logic [15:0] word, input int nbits, input bit extra,
                            input int tail);
    for (int i = 0; i < nbits; i++) begin
      clk_rise[i] = cyc;
      Rx = 1'b1;
      wait_cyc(PW);
      Rx = 1'b0;
      if (word[i]) begin
        wait_cyc(doff[i] - PW);
        dat_rise[i] = cyc;
        Rx = 1'b1;
        wait_cyc(PW);
        Rx = 1'b0;
        wait_cyc(sp[i] - doff[i] - PW);
      end else begin
        wait_cyc(sp[i] - PW);
      end
    end
    if (extra) begin
      clk_rise[16] = cyc;
      Rx = 1'b1;
      wait_cyc(PW);
      Rx = 1'b0;
    end
    wait_cyc(tail);
  endtask

  task automatic test_reset();
    wait_cyc(4);
    n_checks++;
    if (go !== 1'b0) begin n_fail++; $display("FAIL reset_go: got %b, required 0", go); end
    n_checks++;
    if (flp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", flp_err); end
    n_checks++;
    if (nlp !== 1'b0) begin n_fail++; $display("FAIL reset_nlp: got %b, required 0", nlp); end
    n_checks++;
    if (flp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h, required 0000", flp_data); end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_transmitter();
    ev_t e, o;
    wait_cyc(QUIET);
    set_nominal();
    send_burst(16'hA5C3, 16, 1'b0, 100);
    push_exp(K_GO, 16'hA5C3, clk_rise[15] + LAT_TO);
    last_word = 16'hA5C3;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL xmit_event: got no event, required kind=%b data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL xmit_event: got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL xmit_extra: got %0d unexpected events, required 0", obs_q.size());
      obs_q.delete();
    end
    n_checks++;
    if (flp_data !== 16'hA5C3) begin n_fail++; $display("FAIL xmit_data: got %h, required a5c3", flp_data); end
  endtask

  task automatic test_patterns();
    ev_t e, o;
    wait_cyc(QUIET);
    set_nominal();
    send_burst(16'h0000, 16, 1'b0, 100);
    push_exp(K_GO, 16'h0000, clk_rise[15] + LAT_TO);
    wait_cyc(QUIET);
    send_burst(16'hFFFF, 16, 1'b0, 100);
    push_exp(K_GO, 16'hFFFF, clk_rise[15] + LAT_TO);
    last_word = 16'hFFFF;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL pattern_event: got no event, required kind=%b data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL pattern_event: got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL pattern_extra: got %0d unexpected events, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_nlp();
    ev_t e, o;
    int  rise;
    wait_cyc(QUIET);
    rise = cyc;
    Rx = 1'b1;
    wait_cyc(PW);
    Rx = 1'b0;
    push_exp(K_NLP, last_word, rise + LAT_TO);
    wait_cyc(400);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL nlp_event: got no event, required kind=%b data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL nlp_event: got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL nlp_extra: got %0d unexpected events, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_late_data();
    ev_t e, o;
    wait_cyc(QUIET);
    set_nominal();
    doff[5] = 180;
    send_burst(16'h5A3C, 16, 1'b0, 100);
    push_exp(K_ERR, last_word, dat_rise[5] + LAT_EDGE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL late_event: got no event, required kind=%b data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL late_event: got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL late_extra: got %0d unexpected events, required 0", obs_q.size());
      obs_q.delete();
    end
    n_checks++;
    if (flp_data !== last_word) begin n_fail++; $display("FAIL late_hold: got %h, required %h", flp_data, last_word); end
  endtask

  // Pulses placed exactly on every window bound (an edge Rx-rise offset of
  // k+1 lands at cnt=k), then just outside the lower data and clock bounds.
  task automatic test_boundaries();
    ev_t e, o;
    wait_cyc(QUIET);
    for (int i = 0; i < 16; i++) begin
      sp[i]   = (i % 2 == 0) ? CLK_MIN + 1 : CLK_MAX + 1;
      doff[i] = (i % 2 == 0) ? DATA_MIN + 1 : DATA_MAX + 1;
    end
    send_burst(16'h6DB7, 16, 1'b1, 100);
    push_exp(K_GO, 16'h6DB7, clk_rise[16] + LAT_EDGE);
    last_word = 16'h6DB7;

    wait_cyc(QUIET);
    set_nominal();
    doff[0] = DATA_MIN;
    send_burst(16'h0001, 16, 1'b0, 100);
    push_exp(K_ERR, last_word, dat_rise[0] + LAT_EDGE);

    wait_cyc(QUIET);
    set_nominal();
    sp[2] = CLK_MIN;
    send_burst(16'h0000, 16, 1'b0, 100);
    push_exp(K_ERR, last_word, clk_rise[3] + LAT_EDGE);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL bound_event: got no event, required kind=%b data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL bound_event: got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL bound_extra: got %0d unexpected events, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_burst();
    ev_t e, o;
    wait_cyc(QUIET);
    set_nominal();
    send_burst(16'h3C5A, 8, 1'b0, 0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_cyc(1);
      n_checks++;
      if ({go, flp_err, nlp} !== 3'b000 || flp_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL midrst_outputs: got go/err/nlp=%b data=%h, required 000 0000",
                 {go, flp_err, nlp}, flp_data);
      end
    end
    rst_n = 1'b1;
    wait_cyc(QUIET);
    send_burst(16'hC3A5, 16, 1'b0, 100);
    push_exp(K_GO, 16'hC3A5, clk_rise[15] + LAT_TO);
    last_word = 16'hC3A5;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL midrst_event: got no event, required kind=%b data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL midrst_event: got kind=%b data=%h cyc=%0d, required kind=%b data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_extra: got %0d unexpected events, required 0", obs_q.size());
      obs_q.delete();
    end
    n_checks++;
    if (flp_data !== 16'hC3A5) begin n_fail++; $display("FAIL midrst_data: got %h, required c3a5", flp_data); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_transmitter();
    test_patterns();
    test_nlp();
    test_late_data();
    test_boundaries();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
